step_run_controller: RTL

- Sequences the single-cycle ARM-subset processor in the board top-level by generating its clock-enable `cpu_en`. The processor runs no cycles unless this block permits it.
- Three operating modes:
  - Halted.
  - Single-step: one instruction per debounced button pulse.
  - Free-run: one instruction every RUN_DIV clocks.
- Halts on a PC breakpoint.
- Sits between the debouncer outputs and the processor's enable input. Its status outputs drive the LED and HEX debug logic.

---
 rtl/ctrl_pkg.sv | 30 +++
 rtl/issue_timer.sv | 59 +++++
 rtl/step_run_controller.sv | 132 +++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// -----------------------------------------------------------------------------
// ctrl_pkg
// Shared types and constants for the processor debug/sequencing logic.
//   ctrl_mode_t  : step/run controller state, also driven out as its `mode`
//   instr_type_t : decoded instruction class, shared with the decoder
//   CLK_HZ       : board system clock frequency
// -----------------------------------------------------------------------------
package ctrl_pkg;

  localparam int CLK_HZ = 50_000_000;

  typedef enum logic [1:0] {
    HALT  = 2'd0,
    STEP  = 2'd1,
    RUN   = 2'd2,
    BREAK = 2'd3
  } ctrl_mode_t;

  typedef enum logic [2:0] {
    INSTR_OTHER = 3'd0,
    INSTR_MOV   = 3'd1,
    INSTR_STR   = 3'd2,
    INSTR_LDR   = 3'd3,
    INSTR_ADD   = 3'd4,
    INSTR_SUB   = 3'd5,
    INSTR_AND   = 3'd6,
    INSTR_B     = 3'd7
  } instr_type_t;

endpackage

// File: rtl/issue_timer.sv
// -----------------------------------------------------------------------------
// issue_timer
// Burst counter and free-run divider for step_run_controller.
//   clk, reset   : system clock, synchronous active-high reset
//   start        : begin a burst; issue_active rises on the next clock
//   run          : enables the divider; the divider is held at 0 while low
//   issue_active : high for exactly STEP_CYCLES consecutive clocks per burst
//   issue_done   : high on the last clock of a burst
//   tick         : high while running and the divider is at 0 (issue start slot)
// -----------------------------------------------------------------------------
module issue_timer #(
  parameter int STEP_CYCLES = 1,
  parameter int RUN_DIV     = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic run,
  output logic issue_active,
  output logic issue_done,
  output logic tick
);

  localparam int BW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int DW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(STEP_CYCLES - 1);
  localparam logic [DW-1:0] DIV_LAST   = DW'(RUN_DIV - 1);

  logic [BW-1:0] burst_cnt;
  logic [DW-1:0] div_cnt;

  assign issue_done = issue_active && (burst_cnt == BURST_LAST);
  assign tick       = run && (div_cnt == '0);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      issue_active <= 1'b0;
      burst_cnt    <= '0;
      div_cnt      <= '0;
    end else begin
      if (start) begin
        issue_active <= 1'b1;
        burst_cnt    <= '0;
      end else if (issue_done) begin
        issue_active <= 1'b0;
        burst_cnt    <= '0;
      end else if (issue_active) begin
        burst_cnt <= burst_cnt + BW'(1);
      end

      // Holding the divider at 0 outside RUN makes the first RUN clock a tick.
      if (!run || div_cnt == DIV_LAST) div_cnt <= '0;
      else                             div_cnt <= div_cnt + DW'(1);
    end
  end

endmodule

// File: rtl/step_run_controller.sv
// -----------------------------------------------------------------------------
// step_run_controller
// Generates the clock enable of the single-cycle processor: halted, single-step
// (one issue per step_pulse) or free-run (one issue every RUN_DIV clocks), with
// a PC breakpoint checked at every RUN issue start.
// Optional macro TYPE_BREAK_EN adds an instruction-class breakpoint
// (ports brk_type, brk_type_valid).
//   clk, reset     : 50 MHz clock, synchronous active-high reset
//   step_pulse     : request one instruction (debounced pulse)
//   run_pulse      : toggle free-run / halt (debounced pulse)
//   pc, instr_type : current processor PC and decoded instruction class
//   bp_addr        : breakpoint address (word-aligned), bp_valid arms it
//   cpu_en         : processor clock enable (STEP_CYCLES clocks per issue)
//   mode           : 0 HALT, 1 STEP, 2 RUN, 3 BREAK
//   bp_hit         : high while in BREAK
//   retired        : completed issues, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module step_run_controller
  import ctrl_pkg::*;
#(
  parameter int STEP_CYCLES = 1,
  parameter int RUN_DIV     = CLK_HZ / 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step_pulse,
  input  logic             run_pulse,
  input  logic [31:0]      pc,
  input  logic [2:0]       instr_type,
  input  logic [31:0]      bp_addr,
  input  logic             bp_valid,
`ifdef TYPE_BREAK_EN
  input  logic [2:0]       brk_type,
  input  logic             brk_type_valid,
`endif
  output logic             cpu_en,
  output logic [1:0]       mode,
  output logic             bp_hit,
  output logic [CNT_W-1:0] retired
);

  ctrl_mode_t state;
  logic       skip;       // next RUN issue ignores the breakpoint match
  logic       halt_pend;  // run_pulse seen mid-burst; halt when it finishes
  logic       match;
  logic       start;
  logic       tick;
  logic       issue_active;
  logic       issue_done;

`ifdef TYPE_BREAK_EN
  assign match = (bp_valid && pc == bp_addr) ||
                 (brk_type_valid && instr_type == brk_type);
`else
  assign match = bp_valid && pc == bp_addr;
  logic unused_instr_type;
  assign unused_instr_type = ^instr_type;
`endif

  issue_timer #(
    .STEP_CYCLES (STEP_CYCLES),
    .RUN_DIV     (RUN_DIV)
  ) u_issue_timer (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .run          (state == RUN),
    .issue_active (issue_active),
    .issue_done   (issue_done),
    .tick         (tick)
  );

  // Issue start decision is made the cycle before cpu_en rises.
  always_comb begin
    start = 1'b0;
    case (state)
      HALT, BREAK: start = step_pulse && !run_pulse;
      RUN:         start = tick && !run_pulse && (skip || !match);
      default:     start = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= HALT;
      skip      <= 1'b0;
      halt_pend <= 1'b0;
      retired   <= '0;
    end else begin
      if (issue_done) retired <= retired + CNT_W'(1);

      case (state)
        HALT: begin
          if (run_pulse)       state <= RUN;
          else if (step_pulse) state <= STEP;
        end
        STEP: begin
          if (issue_done) state <= HALT;
        end
        RUN: begin
          // A halt request never truncates a burst.
          if ((run_pulse || halt_pend) && (!issue_active || issue_done)) begin
            state     <= HALT;
            halt_pend <= 1'b0;
            skip      <= 1'b0;
          end else begin
            if (run_pulse) halt_pend <= 1'b1;
            if (tick) begin
              if (!skip && match) state <= BREAK;
              skip <= 1'b0;
            end
          end
        end
        BREAK: begin
          if (run_pulse) begin
            state <= RUN;
            skip  <= 1'b1;
          end else if (step_pulse) begin
            state <= STEP;
          end
        end
        default: state <= HALT;
      endcase
    end
  end

  assign cpu_en = issue_active;
  assign mode   = state;
  assign bp_hit = (state == BREAK);

endmodule
